// File: rtl/pwm_duty_arbiter_if.sv
// Bundle of requester handshakes and the FIFO write port for pwm_duty_arbiter.
// master = requesters + FIFO side, slave = the arbiter.
interface pwm_duty_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 12
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         w_data;
    logic                          w_en;
    logic                          full;
    logic [IDW-1:0]                grant_id;
    logic                          busy;

    modport master (
        output req_valid, req_data, full,
        input  req_ready, w_data, w_en, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, full,
        output req_ready, w_data, w_en, grant_id, busy
    );
endinterface

// File: rtl/pwm_duty_arbiter.sv
// Round-robin write-side arbiter for the PWM duty FIFO with write holdoff.
// Define PWM_DUTY_ARB_CLAMP_EN to clamp accepted duty values to MAX_DUTY.
module pwm_duty_arbiter #(
    parameter int                    NUM_REQ    = 4,
    parameter int                    DATA_WIDTH = 12,
    parameter int                    HOLDOFF    = 3,
    parameter logic [DATA_WIDTH-1:0] MAX_DUTY   = 12'd4000
) (
    input  logic              clk,
    input  logic              rst,
    pwm_duty_arbiter_if.slave bus
);

    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW    = IDW + 1;
    localparam int CW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int HLOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLD
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [IDW-1:0]        last_q;
    logic [IDW-1:0]        grant_q;
    logic [DATA_WIDTH-1:0] w_data_q;

    logic                  hit;
    logic [IDW-1:0]        pick;
    logic [IW-1:0]         idx_w;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  accept;
    logic                  wr_fire;

    // Scan last+1, last+2, ... with wrap; first valid requester wins.
    always_comb begin
        hit   = 1'b0;
        pick  = '0;
        idx_w = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_w = {1'b0, last_q} + IW'(i);
            if (idx_w >= IW'(NUM_REQ)) begin
                idx_w = idx_w - IW'(NUM_REQ);
            end
            if (!hit && bus.req_valid[idx_w[IDW-1:0]]) begin
                hit  = 1'b1;
                pick = idx_w[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDW'(i)) begin
                sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef PWM_DUTY_ARB_CLAMP_EN
    assign cap_data = (sel_data > MAX_DUTY) ? MAX_DUTY : sel_data;
`else
    logic unused_max_duty;
    assign unused_max_duty = ^MAX_DUTY;
    assign cap_data        = sel_data;
`endif

    // Reset gates the handshake so no strobe leaks while rst is low.
    assign accept  = rst && (state_q == IDLE) && hit && !bus.full;
    assign wr_fire = (state_q == WRITE) && !bus.full;

    assign bus.req_ready = accept ? (NUM_REQ'(1) << pick) : '0;
    assign bus.w_en      = wr_fire;
    assign bus.w_data    = w_data_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (wr_fire) begin
                    if (HOLDOFF > 0) begin
                        state_d = HOLD;
                        cnt_d   = CW'(HLOAD);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= IDW'(NUM_REQ - 1);
            grant_q  <= '0;
            w_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                w_data_q <= cap_data;
                grant_q  <= pick;
                last_q   <= pick;
            end
        end
    end

    a_ready_onehot: assert property (
        @(posedge clk) disable iff (!rst)
        $onehot0(bus.req_ready)
    );

    a_ready_only_idle: assert property (
        @(posedge clk) disable iff (!rst)
        (bus.req_ready != '0) |-> (state_q == IDLE)
    );

    a_wen_only_write: assert property (
        @(posedge clk) disable iff (!rst)
        bus.w_en |-> (state_q == WRITE)
    );

endmodule

// File: tb/tb_pwm_duty_arbiter.sv
// Scoreboard bench for pwm_duty_arbiter: a cycle-level reference model
// predicts grants and writes, a monitor pops them on every FIFO write.
module tb_pwm_duty_arbiter;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int HO = 3;

`ifdef PWM_DUTY_ARB_CLAMP_EN
    localparam logic [DW-1:0] CLAMP_EXP = 12'd4000;
`else
    localparam logic [DW-1:0] CLAMP_EXP = 12'hFFF;
`endif

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  vld;
    logic [DW-1:0] dat [N];
    logic          full;

    exp_t          sb [$];
    int            log_id [$];
    logic [DW-1:0] log_data [$];
    int            log_cyc [$];

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            seq   = 0;
    int            m_last = N - 1;
    bit            m_pend = 0;
    int            m_next = 0;
    logic [N-1:0]  rdy_s = '0;

    logic [N-1:0]  er;
    logic          ew;
    logic          eb;
    int            g;
    exp_t          e;
    int            n;

    pwm_duty_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    pwm_duty_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .HOLDOFF   (HO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.req_valid = vld;
    assign bus.full      = full;

    always_comb begin
        bus.req_data = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_data[i*DW +: DW] = dat[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_data(input logic [DW-1:0] d);
`ifdef PWM_DUTY_ARB_CLAMP_EN
        return (d > 12'd4000) ? 12'd4000 : d;
`else
        return d;
`endif
    endfunction

    // Reference model: accepts allowed when nothing is pending and the
    // holdoff window since the last write has elapsed.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_wen", 32'(bus.w_en), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_grant", 32'(bus.grant_id), 32'd0);
            chk("rst_wdata", 32'(bus.w_data), 32'd0);
            m_pend = 0;
            m_last = N - 1;
            m_next = 0;
            sb.delete();
            rdy_s = '0;
        end else begin
            er = '0;
            ew = 1'b0;
            g  = -1;
            if (m_pend) begin
                ew = !full;
            end else if (cyc >= m_next && !full) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && vld[(m_last + k) % N]) begin
                        g = (m_last + k) % N;
                    end
                end
                if (g >= 0) begin
                    er[g] = 1'b1;
                end
            end
            eb = m_pend || (cyc < m_next);
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            chk("w_en", 32'(bus.w_en), 32'(ew));
            chk("busy", 32'(bus.busy), 32'(eb));
            rdy_s = bus.req_ready;
            if (m_pend && !full) begin
                m_pend = 0;
                m_next = cyc + HO + 1;
            end else if (g >= 0) begin
                sb.push_back('{g, ref_data(dat[g])});
                m_pend = 1;
                m_last = g;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst && bus.w_en) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL spurious_write actual=%0h required=none t=%0t",
                         bus.w_data, $time);
            end else begin
                e = sb.pop_front();
                chk("sb_w_data", 32'(bus.w_data), 32'(e.data));
                chk("sb_grant_id", 32'(bus.grant_id), 32'(e.id));
            end
            log_id.push_back(int'(bus.grant_id));
            log_data.push_back(bus.w_data);
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_id.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic wait_ready(input int i, output int cnt);
        cnt = 0;
        #1;
        while (!bus.req_ready[i] && cnt < 30) begin
            @(posedge clk);
            #2;
            cnt++;
        end
        total++;
        if (cnt >= 30) begin
            bad++;
            $display("FAIL ready_timeout actual=none required=ready%0d", i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic rr_cycles(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rdy_s[i]) begin
                    seq++;
                    dat[i] = DW'(i * 256 + seq);
                end
            end
            tick();
        end
    endtask

    initial begin
        vld  = '0;
        full = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_wen", 32'(bus.w_en), 32'd0);
            chk("idle_ready", 32'(bus.req_ready), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_grant", 32'(bus.grant_id), 32'd0);
        end

        vld    = 4'b0010;
        dat[1] = 12'h123;
        wait_ready(1, n);
        chk("single_latency", 32'(n), 32'd0);
        chk("single_ready_vec", 32'(bus.req_ready), 32'h2);
        tick();
        vld = '0;
        chk("single_wen", 32'(bus.w_en), 32'd1);
        chk("single_wdata", 32'(bus.w_data), 32'h123);
        chk("single_grant", 32'(bus.grant_id), 32'd1);
        vld    = 4'b0001;
        dat[0] = 12'h456;
        wait_ready(0, n);
        chk("holdoff_gap", 32'(n), 32'd4);
        tick();
        vld = '0;
        repeat (8) tick();

        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) dat[i] = DW'(i * 256);
        vld = '1;
        rr_cycles(30);
        vld = '0;
        repeat (8) tick();
        chk("rr_count", 32'(log_id.size() >= 5), 32'd1);
        if (log_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("rr_order", 32'(log_id[k]), 32'(k % N));
            end
            for (int k = 1; k < 5; k++) begin
                chk("rr_spacing", 32'(log_cyc[k] - log_cyc[k-1]), 32'd5);
            end
        end

        clear_logs();
        vld    = 4'b0100;
        dat[2] = 12'hABC;
        wait_ready(2, n);
        tick();
        vld  = '0;
        full = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_wen_low", 32'(bus.w_en), 32'd0);
            chk("bp_wdata_hold", 32'(bus.w_data), 32'hABC);
            @(posedge clk);
            #1;
        end
        full = 1'b0;
        #1;
        chk("bp_wen_release", 32'(bus.w_en), 32'd1);
        repeat (8) tick();
        chk("bp_one_write", 32'(log_id.size()), 32'd1);

        vld    = 4'b1000;
        dat[3] = 12'h321;
        wait_ready(3, n);
        tick();
        vld  = '0;
        full = 1'b1;
        #1;
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_wen_async", 32'(bus.w_en), 32'd0);
        chk("mid_busy_async", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        full = 1'b0;
        clear_logs();
        for (int i = 0; i < N; i++) dat[i] = DW'(i * 256 + 7);
        vld = '1;
        rr_cycles(12);
        vld = '0;
        repeat (8) tick();
        chk("mid_first_count", 32'(log_id.size() >= 1), 32'd1);
        if (log_id.size() >= 1) begin
            chk("mid_first_grant", 32'(log_id[0]), 32'd0);
            chk("mid_first_data", 32'(log_data[0]), 32'h007);
        end

        clear_logs();
        vld    = 4'b0001;
        dat[0] = 12'hFFF;
        wait_ready(0, n);
        tick();
        vld = '0;
        chk("clamp_wen", 32'(bus.w_en), 32'd1);
        chk("clamp_wdata", 32'(bus.w_data), 32'(CLAMP_EXP));
        repeat (6) tick();

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (vld[i] && rdy_s[i]) begin
                    vld[i] = ($urandom % 3) != 0;
                    dat[i] = DW'($urandom);
                end else if (vld[i]) begin
                    if ($urandom % 20 == 0) vld[i] = 1'b0;
                end else if ($urandom % 4 == 0) begin
                    vld[i] = 1'b1;
                    dat[i] = DW'($urandom);
                end
            end
            full = ($urandom % 4) == 0;
            tick();
        end

        vld  = '0;
        full = 1'b0;
        n    = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        repeat (6) tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
